// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM peripheral: register map, SPI command
// byte layout and the instruction decoder state encoding.
package pwm_pkg;

  // Register map of the PWM peripheral (16-bit registers, byte-addressed by lane)
  localparam logic [5:0] ADDR_CTRL      = 6'h00;
  localparam logic [5:0] ADDR_STATUS    = 6'h01;
  localparam logic [5:0] ADDR_PRESCALE  = 6'h02;
  localparam logic [5:0] ADDR_PERIOD    = 6'h03;
  localparam logic [5:0] ADDR_CH0_DUTY  = 6'h04;
  localparam logic [5:0] ADDR_CH1_DUTY  = 6'h05;
  localparam logic [5:0] ADDR_CH2_DUTY  = 6'h06;
  localparam logic [5:0] ADDR_CH3_DUTY  = 6'h07;
  localparam logic [5:0] ADDR_CH0_PHASE = 6'h08;
  localparam logic [5:0] ADDR_CH1_PHASE = 6'h09;
  localparam logic [5:0] ADDR_CH2_PHASE = 6'h0A;
  localparam logic [5:0] ADDR_CH3_PHASE = 6'h0B;
  localparam logic [5:0] ADDR_IRQ_EN    = 6'h0C;
  localparam logic [5:0] ADDR_IRQ_STAT  = 6'h0D;

  // Highest mapped address; anything above it is silently skipped
  localparam logic [5:0] MAX_ADDR = ADDR_IRQ_STAT;

  // Command byte layout: bit7 = write, bit6 = high byte lane, bits[5:0] = address
  localparam int CMD_RW_BIT = 7;
  localparam int CMD_HI_BIT = 6;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    WR,
    RD1,
    RD2,
    RESP,
    SKIP
  } dec_state_t;

  // True when the address hits a real register
  function automatic logic addr_mapped(input logic [5:0] a, input logic [5:0] max_addr);
    return a <= max_addr;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// SPI instruction decoder: turns a command byte (plus a data byte for writes)
// into single-cycle register-file strobes, and returns read data on data_out
// for the dummy byte that follows a read command.
module instr_decoder
  import pwm_pkg::*;
#(
  parameter logic [5:0] MAX_ADDR = 6'h0D
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame,
  input  logic       byte_sync,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  output logic       read,
  output logic       write,
  output logic [5:0] addr,
  output logic       hi_sel,
  output logic [7:0] data_write,
  input  logic [7:0] data_read
);

  dec_state_t state;

  // Decoder FSM; every output is a flop so strobes are glitch-free and
  // addr/hi_sel/data_write only move in states where no strobe is active.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      read           <= 1'b0;
      write          <= 1'b0;
      addr           <= 6'h00;
      hi_sel         <= 1'b0;
      data_write     <= 8'h00;
      data_out       <= 8'h00;
      data_out_valid <= 1'b0;
    end else begin
      // Strobes and the valid pulse are one-shot unless re-armed below
      read           <= 1'b0;
      write          <= 1'b0;
      data_out_valid <= 1'b0;

      if (!frame) begin
        // Chip-select gone: drop whatever was in progress, including a
        // write that is still waiting for its data byte
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (byte_sync) begin
              addr   <= data_in[5:0];
              hi_sel <= data_in[CMD_HI_BIT];
              if (!addr_mapped(data_in[5:0], MAX_ADDR)) begin
                state <= SKIP;
                // Unmapped reads still answer, with zero, so the host
                // always gets a defined byte back
                if (!data_in[CMD_RW_BIT]) begin
                  data_out       <= 8'h00;
                  data_out_valid <= 1'b1;
                end
              end else if (data_in[CMD_RW_BIT]) begin
                state <= WAIT_DATA;
              end else begin
                state <= RD1;
                read  <= 1'b1;
              end
            end
          end
          WAIT_DATA: begin
            if (byte_sync) begin
              data_write <= data_in;
              write      <= 1'b1;
              state      <= WR;
            end
          end
          WR: begin
            state <= IDLE;
          end
          RD1: begin
            read  <= 1'b1;
            state <= RD2;
          end
          RD2: begin
            // Register file data is valid by the end of the second read cycle
            data_out       <= data_read;
            data_out_valid <= 1'b1;
            state          <= RESP;
          end
          RESP, SKIP: begin
            // The next byte is the dummy that shifts data_out (or, for an
            // unmapped write, the discarded data byte)
            if (byte_sync) begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/instr_decoder.md
INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 SHALL have parameter MAX_ADDR, default 6'h0D: highest mapped register address.
REQ-002 SHALL have port clk  in  1  peripheral clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port frame  in  1  high while the SPI chip-select is active.
REQ-005 SHALL have port byte_sync  in  1  one-cycle pulse: a new received SPI byte is valid on data_in.
REQ-006 SHALL have port data_in  in  8  received SPI byte.
REQ-007 SHALL have port data_out  out  8  byte to shift out on the next SPI byte.
REQ-008 SHALL have port data_out_valid  out  1  one-cycle pulse when data_out is loaded.
REQ-009 SHALL have port read  out  1  register-file read strobe.
REQ-010 SHALL have port write  out  1  register-file write strobe.
REQ-011 SHALL have port addr  out  6  register address.
REQ-012 SHALL have port hi_sel  out  1  byte lane of the addressed register: 0 = bits[7:0], 1 = bits[15:8].
REQ-013 SHALL have port data_write  out  8  write data to the register file.
REQ-014 SHALL have port data_read  in  8  read data from the register file.

Function
REQ-015 SHALL decode the command byte as: bit7 = 1 write / 0 read; bit6 = hi_sel; bits[5:0] = addr.
REQ-016 SHALL implement FSM states IDLE, WAIT_DATA, WR, RD1, RD2, RESP, SKIP.
REQ-017 In IDLE, a byte_sync with frame=1 SHALL latch addr and hi_sel from the command byte, then go to WAIT_DATA if bit7=1 and to RD1 if bit7=0.
REQ-018 If the command addr > MAX_ADDR, the FSM SHALL go to SKIP instead, and no strobe SHALL be issued.
REQ-019 In WAIT_DATA, a byte_sync SHALL latch data_in into data_write and move to WR.
REQ-020 WR SHALL assert write for exactly one cycle, then return to IDLE.
REQ-021 RD1 and RD2 SHALL each assert read, so read is high for exactly 2 consecutive cycles.
REQ-022 data_read SHALL be sampled on the rising edge that ends RD2 and loaded into data_out.
REQ-023 The cycle after RD2 SHALL enter RESP with data_out_valid high for 1 cycle.
REQ-024 Read latency SHALL be 3 cycles from the command byte_sync to data_out_valid.
REQ-025 RESP SHALL wait for the next byte_sync (the dummy byte that carries data_out out) and then return to IDLE.
REQ-026 For an unmapped read, SKIP SHALL load data_out = 8'h00 and pulse data_out_valid, then behave as RESP.
REQ-027 For an unmapped write, SKIP SHALL consume the data byte and return to IDLE without asserting write.
REQ-028 In WR, RD1 and RD2, a byte_sync SHALL be ignored and SHALL NOT alter state or latched fields.
REQ-029 frame=0 in any state SHALL force IDLE on the next edge.
REQ-030 Strobes already in flight when frame drops SHALL complete their current cycle only: no new strobe the cycle after frame=0, and a partial write SHALL never issue write.
REQ-031 read and write SHALL never be high in the same cycle.
REQ-032 addr, hi_sel and data_write SHALL stay stable for every cycle in which read or write is high.
REQ-033 byte_sync in IDLE with frame=0 SHALL be ignored.

Reset
REQ-034 On rst_n=0 at a rising clk edge, the FSM SHALL go to IDLE.
REQ-035 Reset values SHALL be: read=0, write=0, addr=0, hi_sel=0, data_write=8'h00, data_out=8'h00, data_out_valid=0.
REQ-036 Reset mid-transaction SHALL abort it with no further strobes; this includes a pending write in WAIT_DATA.

Structure
REQ-037 A shared package pwm_pkg SHALL hold:
- register address constants 6'h00..6'h0D and MAX_ADDR;
- command bit positions CMD_RW_BIT=7, CMD_HI_BIT=6;
- the FSM state enum.
REQ-038 The block SHALL be a single module with one registered FSM and no sub-modules.
REQ-039 All outputs SHALL be driven from flops; no combinational path from input to output.

Verification
REQ-040 Write, low lane: frame=1; byte_sync 0x83 then 0x5A.
- Response: one write pulse with addr=0x03, hi_sel=0, data_write=0x5A.
- read stays 0.
REQ-041 Write, high lane: frame=1; byte_sync 0xC0 then 0x12.
- Response: write pulse with addr=0x00, hi_sel=1, data_write=0x12.
REQ-042 Read: command 0x0A, data_read model returns 0xA5 on the second read cycle.
- Response: read high 2 cycles, data_out=0xA5, data_out_valid 3 cycles after the command.
- Dummy byte_sync returns the FSM to IDLE.
REQ-043 Unmapped accesses: command 0x3F (read) and 0xBF+0x77 (write).
- Response: no read/write strobe; the read returns data_out=0x00 with data_out_valid.
REQ-044 Abort: frame drops after command 0x85, before the data byte.
- Response: no write.
- The next frame, 0x8B then 0x01, writes addr=0x0B data 0x01 normally.
REQ-045 Mid-operation reset and concurrency:
- rst_n=0 during RD1: all outputs return to reset values next edge.
- byte_sync injected during RD2: ignored, data_out still loads correctly.
